// File: rtl/ascon_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_collector_pkg
// Purpose  : Shared types and constants for the ASCON cipher collector.
//            Holds the collector FSM state encoding, default message size,
//            tag length and the byte-index width used by the streamer.
// Revision : 1.0 - initial release
// ============================================================================
package ascon_collector_pkg;

  localparam int N_WORDS_DEFAULT = 23;   // 64-bit cipher words per message
  localparam int TAG_BYTES       = 16;   // 128-bit ASCON tag
  localparam int BYTE_CNT_W      = 8;    // byte index width for the streamer
  localparam int WORD_CNT_W      = 5;    // captured-word counter width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WAIT_TAG = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Total number of bytes streamed for a message of n_words cipher words.
  function automatic int stream_bytes(input int n_words);
    return 8 * n_words + TAG_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_cipher_collector_counter.sv
`default_nettype none
// ============================================================================
// Module   : compteur_Nbits
// Purpose  : Generic N-bit up counter with synchronous clear (init_i) and
//            count enable (enable_i). init_i has priority over enable_i.
//            Asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module compteur_Nbits #(
  parameter int N_bits = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_i,
  input  logic              enable_i,
  output logic [N_bits-1:0] count_o
);

  logic [N_bits-1:0] count_q, count_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (init_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ascon_cipher_collector.sv
`default_nettype none
// ============================================================================
// Module   : ascon_cipher_collector
// Purpose  : Collects N_WORDS 64-bit cipher words and a 128-bit tag from an
//            ASCON core into a packed buffer. Optionally streams the message
//            out byte by byte over a valid/ready port.
// Config   : COLLECTOR_STREAM_EN - when defined, compiles in the STREAM state,
//            the byte index counter and the byte port. When undefined the
//            byte port is tied to zero and the tag moves the FSM to DONE.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_cipher_collector
  import ascon_collector_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEFAULT   // must stay below 32 (5-bit count)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [63:0]             cipher_i,
  input  logic                    cipher_valid_i,
  input  logic [127:0]            tag_i,
  input  logic                    end_tag_i,
  input  logic                    byte_ready_i,
  output logic [64*N_WORDS-1:0]   cipher_o,
  output logic [127:0]            tag_o,
  output logic [WORD_CNT_W-1:0]   word_count_o,
  output logic [7:0]              byte_o,
  output logic                    byte_valid_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  localparam logic [WORD_CNT_W-1:0] LAST_WORD  = WORD_CNT_W'(N_WORDS - 1);
  localparam logic [WORD_CNT_W-1:0] FULL_COUNT = WORD_CNT_W'(N_WORDS);

  // Where the FSM goes once the tag has been captured.
`ifdef COLLECTOR_STREAM_EN
  localparam state_t TAG_EXIT_ST = ST_STREAM;
`else
  localparam state_t TAG_EXIT_ST = ST_DONE;
`endif

  state_t                   state_q, state_d;
  logic [N_WORDS-1:0][63:0] cipher_q, cipher_d;
  logic [127:0]             tag_q, tag_d;
  logic                     overflow_q, overflow_d;
  logic [WORD_CNT_W-1:0]    word_count;
  logic                     cnt_init, cnt_en;
  logic                     w_word_take, w_tag_take, w_last_hs;

  // A word is accepted only while collecting and while a slot is free;
  // the count can never run past N_WORDS, so it never wraps.
  assign w_word_take = (state_q == ST_COLLECT) && cipher_valid_i &&
                       (word_count < FULL_COUNT);
  assign w_tag_take  = end_tag_i &&
                       ((state_q == ST_COLLECT) || (state_q == ST_WAIT_TAG));

  // Word counter: cleared by start_i, stepped on each accepted word.
  compteur_Nbits #(
    .N_bits (WORD_CNT_W)
  ) u_word_cnt (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .init_i   (cnt_init),
    .enable_i (cnt_en),
    .count_o  (word_count)
  );

  // Collector next-state: start/abort, word and tag capture, overflow flag.
  always_comb begin
    state_d    = state_q;
    cipher_d   = cipher_q;
    tag_d      = tag_q;
    overflow_d = overflow_q;
    cnt_init   = 1'b0;
    cnt_en     = 1'b0;

    if (start_i) begin
      // Start from any state arms a fresh message and drops the old one.
      cipher_d   = '0;
      tag_d      = '0;
      overflow_d = 1'b0;
      cnt_init   = 1'b1;
      state_d    = ST_COLLECT;
    end else begin
      // Words arriving after collection has ended are discarded but flagged.
      if (cipher_valid_i && (state_q != ST_IDLE) && (state_q != ST_COLLECT)) begin
        overflow_d = 1'b1;
      end

      if (w_word_take) begin
        cipher_d[word_count] = cipher_i;
        cnt_en               = 1'b1;
        if (word_count == LAST_WORD) begin
          state_d = ST_WAIT_TAG;
        end
      end

      // The tag closes the message, even a short one still in COLLECT.
      // Evaluated after the word so a same-cycle word is still kept.
      if (w_tag_take) begin
        tag_d   = tag_i;
        state_d = TAG_EXIT_ST;
      end

      if ((state_q == ST_STREAM) && w_last_hs) begin
        state_d = ST_DONE;
      end
    end
  end

  // Collector state and buffers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cipher_q   <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cipher_q   <= cipher_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef COLLECTOR_STREAM_EN
  localparam int STREAM_W = 64 * N_WORDS + 8 * TAG_BYTES;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE =
    BYTE_CNT_W'(stream_bytes(N_WORDS) - 1);

  logic [BYTE_CNT_W-1:0] byte_idx_q, byte_idx_d, w_next_idx;
  logic [7:0]            byte_q, byte_d;
  logic                  byte_valid_q, byte_valid_d;
  logic [STREAM_W-1:0]   w_stream;

  // Cipher words sit below the tag, so byte i of the stream is simply
  // bits [8i+7:8i] of this concatenation.
  assign w_stream   = {tag_q, cipher_q};
  assign w_next_idx = byte_idx_q + 1'b1;
  assign w_last_hs  = (state_q == ST_STREAM) && byte_valid_q && byte_ready_i &&
                      (byte_idx_q == LAST_BYTE);

  // Byte streamer: first STREAM cycle loads byte 0, each handshake
  // advances, and the byte is held unchanged while the sink stalls.
  always_comb begin
    byte_idx_d   = byte_idx_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;

    if (start_i) begin
      byte_idx_d   = '0;
      byte_d       = '0;
      byte_valid_d = 1'b0;
    end else if (state_q == ST_STREAM) begin
      if (!byte_valid_q) begin
        byte_valid_d = 1'b1;
        byte_d       = w_stream[{byte_idx_q, 3'b000} +: 8];
      end else if (byte_ready_i) begin
        if (byte_idx_q == LAST_BYTE) begin
          byte_valid_d = 1'b0;
        end else begin
          byte_idx_d = w_next_idx;
          byte_d     = w_stream[{w_next_idx, 3'b000} +: 8];
        end
      end
    end
  end

  // Streamer registers; reset drops byte_valid_o asynchronously.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      byte_idx_q   <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
`else
  // No streamer: the byte port is inert and the sink's ready is ignored.
  logic unused_byte_ready;
  assign unused_byte_ready = byte_ready_i;
  assign w_last_hs         = 1'b0;
  assign byte_o            = '0;
  assign byte_valid_o      = 1'b0;
`endif

  assign cipher_o     = cipher_q;
  assign tag_o        = tag_q;
  assign word_count_o = word_count;
  assign overflow_o   = overflow_q;
  assign done_o       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ascon_cipher_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_cipher_collector
// Purpose  : Directed bench for ascon_cipher_collector: a vector table for
//            single-cycle behaviour plus sequences for full message,
//            overflow, simultaneous word/tag, abort and reset mid-stream.
//            Stream checks are active when COLLECTOR_STREAM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ascon_cipher_collector;
  import ascon_collector_pkg::*;

  localparam int NW = N_WORDS_DEFAULT;
`ifdef COLLECTOR_STREAM_EN
  localparam bit STREAM_EN = 1'b1;
`else
  localparam bit STREAM_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [63:0]     cw;
  logic            cv;
  logic [127:0]    tg;
  logic            et;
  logic            ready;
  logic [64*NW-1:0] cipher_o;
  logic [127:0]    tag_o;
  logic [4:0]      word_count_o;
  logic [7:0]      byte_o;
  logic            byte_valid_o;
  logic            done_o;
  logic            overflow_o;

  int n_vec = 0;
  int n_bad = 0;

  ascon_cipher_collector #(.N_WORDS(NW)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .start_i        (start),
    .cipher_i       (cw),
    .cipher_valid_i (cv),
    .tag_i          (tg),
    .end_tag_i      (et),
    .byte_ready_i   (ready),
    .cipher_o       (cipher_o),
    .tag_o          (tag_o),
    .word_count_o   (word_count_o),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         st;
    logic         cv;
    logic [63:0]  cw;
    logic         et;
    logic [127:0] tg;
    logic [4:0]   wc;
    logic         dn;   // done when the streamer is absent
    logic         ov;
    logic [127:0] tag;
    logic [63:0]  s1;   // cipher slot 1
    logic         bv;   // byte_valid when the streamer is present
    logic [7:0]   by;   // byte when the streamer is present
  } vec_t;

  vec_t tbl [11];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_cipher(input string name, input logic [64*NW-1:0] exp);
    n_vec++;
    if (cipher_o !== exp) begin
      n_bad++;
      for (int k = 0; k < NW; k++) begin
        if (cipher_o[64*k +: 64] !== exp[64*k +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, k,
                   cipher_o[64*k +: 64], exp[64*k +: 64]);
          break;
        end
      end
    end
  endtask

  // Expected stream byte i for the full message (words k, tag 0xA5).
  function automatic logic [7:0] exp_byte(input int i);
    if (i < 8*NW) return (i % 8 == 0) ? 8'(i / 8) : 8'h00;
    return (i == 8*NW) ? 8'hA5 : 8'h00;
  endfunction

  task automatic send_words(input int n);
    for (int k = 0; k < n; k++) begin
      cv = 1'b1;
      cw = 64'(k);
      cyc();
    end
    cv = 1'b0;
    cw = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  logic [64*NW-1:0] exp_full;
  localparam logic [63:0] S1 = 64'h2222_0000_0000_0002;

  initial begin
    int got;
    int guard;
    int hs;
    logic stalled;
    logic [7:0] held;

    for (int k = 0; k < NW; k++) exp_full[64*k +: 64] = 64'(k);

    //            st cv cw                 et tg            wc dn ov tag          s1  bv by
    tbl[0]  = '{1'b0,1'b1,64'h11,   1'b0,128'h0,     5'd0,1'b0,1'b0,128'h0,     64'h0,1'b0,8'h00};
    tbl[1]  = '{1'b1,1'b0,64'h0,    1'b0,128'h0,     5'd0,1'b0,1'b0,128'h0,     64'h0,1'b0,8'h00};
    tbl[2]  = '{1'b0,1'b1,64'h1111, 1'b0,128'h0,     5'd1,1'b0,1'b0,128'h0,     64'h0,1'b0,8'h00};
    tbl[3]  = '{1'b0,1'b1,S1,       1'b0,128'h0,     5'd2,1'b0,1'b0,128'h0,     S1,   1'b0,8'h00};
    tbl[4]  = '{1'b0,1'b0,64'h0,    1'b0,128'h0,     5'd2,1'b0,1'b0,128'h0,     S1,   1'b0,8'h00};
    tbl[5]  = '{1'b0,1'b0,64'h0,    1'b1,128'hDEAD,  5'd2,1'b1,1'b0,128'hDEAD,  S1,   1'b0,8'h00};
    tbl[6]  = '{1'b0,1'b1,64'h99,   1'b0,128'h0,     5'd2,1'b1,1'b1,128'hDEAD,  S1,   1'b1,8'h11};
    tbl[7]  = '{1'b0,1'b0,64'h0,    1'b0,128'h0,     5'd2,1'b1,1'b1,128'hDEAD,  S1,   1'b1,8'h11};
    tbl[8]  = '{1'b1,1'b0,64'h0,    1'b0,128'h0,     5'd0,1'b0,1'b0,128'h0,     64'h0,1'b0,8'h00};
    tbl[9]  = '{1'b0,1'b1,64'h77,   1'b1,128'hBEEF,  5'd1,1'b1,1'b0,128'hBEEF,  64'h0,1'b0,8'h00};
    tbl[10] = '{1'b1,1'b0,64'h0,    1'b0,128'h0,     5'd0,1'b0,1'b0,128'h0,     64'h0,1'b0,8'h00};

    reset = 1'b1; start = 1'b0; cv = 1'b0; cw = '0; et = 1'b0; tg = '0; ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset values
    cmp_cipher("rst_cipher", '0);
    cmp("rst_tag", tag_o, 128'h0);
    cmp("rst_wc", 128'(word_count_o), 128'h0);
    cmp("rst_byte", 128'(byte_o), 128'h0);
    cmp("rst_bv", 128'(byte_valid_o), 128'h0);
    cmp("rst_done", 128'(done_o), 128'h0);
    cmp("rst_ovf", 128'(overflow_o), 128'h0);
    reset = 1'b0;

    // Vector table (byte_ready held low)
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; cv = tbl[i].cv; cw = tbl[i].cw; et = tbl[i].et; tg = tbl[i].tg;
      cyc();
      cmp($sformatf("v%0d_wc", i), 128'(word_count_o), 128'(tbl[i].wc));
      cmp($sformatf("v%0d_done", i), 128'(done_o), 128'(STREAM_EN ? 1'b0 : tbl[i].dn));
      cmp($sformatf("v%0d_ovf", i), 128'(overflow_o), 128'(tbl[i].ov));
      cmp($sformatf("v%0d_tag", i), tag_o, tbl[i].tag);
      cmp($sformatf("v%0d_slot1", i), 128'(cipher_o[127:64]), 128'(tbl[i].s1));
      cmp($sformatf("v%0d_bv", i), 128'(byte_valid_o), 128'(STREAM_EN ? tbl[i].bv : 1'b0));
      cmp($sformatf("v%0d_byte", i), 128'(byte_o), 128'(STREAM_EN ? tbl[i].by : 8'h00));
    end
    start = 1'b0; cv = 1'b0; cw = '0; et = 1'b0; tg = '0;

    // Full message, then overflow in WAIT_TAG, then tag
    pulse_start();
    send_words(NW);
    cmp("full_wc", 128'(word_count_o), 128'(NW));
    cmp_cipher("full_cipher", exp_full);
    cv = 1'b1; cw = 64'hFF;
    cyc();
    cv = 1'b0; cw = '0;
    cmp("ovf_flag", 128'(overflow_o), 128'h1);
    cmp("ovf_wc", 128'(word_count_o), 128'(NW));
    cmp_cipher("ovf_cipher", exp_full);
    et = 1'b1; tg = 128'hA5;
    cyc();
    et = 1'b0; tg = '0;
    cmp("full_tag", tag_o, 128'hA5);
`ifdef COLLECTOR_STREAM_EN
    cmp("stream_bv_entry", 128'(byte_valid_o), 128'h0);
    cyc();
    cmp("stream_bv_rise", 128'(byte_valid_o), 128'h1);
    cmp("stream_first_byte", 128'(byte_o), 128'h0);
    got = 0; guard = 0; stalled = 1'b0; held = 8'h00;
    while (got < 8*NW + TAG_BYTES && guard < 2000) begin
      if (stalled) cmp("stall_hold", 128'(byte_o), 128'(held));
      ready = (guard % 2 == 0);
      if (byte_valid_o && ready) begin
        cmp($sformatf("stream_byte%0d", got), 128'(byte_o), 128'(exp_byte(got)));
        got++;
      end
      stalled = byte_valid_o && !ready;
      held    = byte_o;
      cyc();
      guard++;
    end
    ready = 1'b0;
    cmp("stream_total", 128'(got), 128'(8*NW + TAG_BYTES));
    cmp("stream_done", 128'(done_o), 128'h1);
    cmp("stream_bv_end", 128'(byte_valid_o), 128'h0);
`else
    cmp("full_done", 128'(done_o), 128'h1);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    cmp("nostream_bv", 128'(byte_valid_o), 128'h0);
    cmp("nostream_byte", 128'(byte_o), 128'h0);
    cmp("done_hold", 128'(done_o), 128'h1);
`endif
    cmp_cipher("done_cipher_hold", exp_full);
    cmp("done_tag_hold", tag_o, 128'hA5);

    // Last word and tag in the same cycle
    pulse_start();
    send_words(NW - 1);
    cv = 1'b1; cw = 64'(NW - 1); et = 1'b1; tg = 128'h5A5A;
    cyc();
    cv = 1'b0; cw = '0;
    cmp("sim_wc", 128'(word_count_o), 128'(NW));
    cmp("sim_tag", tag_o, 128'h5A5A);
    cmp_cipher("sim_cipher", exp_full);
    tg = 128'h1234;   // a tag here must be ignored once WAIT_TAG is left
    cyc();
    et = 1'b0; tg = '0;
    cmp("sim_tag_kept", tag_o, 128'h5A5A);
`ifdef COLLECTOR_STREAM_EN
    cmp("sim_bv", 128'(byte_valid_o), 128'h1);
`else
    cmp("sim_done", 128'(done_o), 128'h1);
`endif

    // Abort after word 5
    pulse_start();
    send_words(6);
    cmp("abort_wc_pre", 128'(word_count_o), 128'h6);
    pulse_start();
    cmp("abort_wc", 128'(word_count_o), 128'h0);
    cmp_cipher("abort_cipher", '0);
    cv = 1'b1; cw = 64'hCAFE;
    cyc();
    cv = 1'b0; cw = '0;
    cmp("abort_collect_wc", 128'(word_count_o), 128'h1);
    cmp("abort_collect_w0", 128'(cipher_o[63:0]), 128'hCAFE);

    // Reset mid-stream (mid-DONE without the streamer)
    pulse_start();
    send_words(NW);
    et = 1'b1; tg = 128'hA5;
    cyc();
    et = 1'b0; tg = '0;
`ifdef COLLECTOR_STREAM_EN
    ready = 1'b1;
    hs = 0; guard = 0;
    while (hs < 10 && guard < 100) begin
      if (byte_valid_o) hs++;
      cyc();
      guard++;
    end
    cmp("hs_before_reset", 128'(hs), 128'd10);
    cmp("bv_before_reset", 128'(byte_valid_o), 128'h1);
`endif
    #2;
    reset = 1'b1;
    #1;
    cmp("mrst_bv", 128'(byte_valid_o), 128'h0);
    cmp("mrst_byte", 128'(byte_o), 128'h0);
    cmp("mrst_done", 128'(done_o), 128'h0);
    cmp("mrst_ovf", 128'(overflow_o), 128'h0);
    cmp("mrst_wc", 128'(word_count_o), 128'h0);
    cmp("mrst_tag", tag_o, 128'h0);
    cmp_cipher("mrst_cipher", '0);
    ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cyc();
    pulse_start();
    cv = 1'b1; cw = 64'hBEEF;
    cyc();
    cv = 1'b0; cw = '0;
    cmp("fresh_wc", 128'(word_count_o), 128'h1);
    cmp("fresh_w0", 128'(cipher_o[63:0]), 128'hBEEF);
    cmp("fresh_done", 128'(done_o), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
